// File: rtl/fft_sample_buffer.sv
// Single-frame complex sample buffer: fill in arrival order, then drain.
// Define FFT_SAMPLE_BUFFER_BITREV_EN to drain in bit-reversed address order.
module fft_sample_buffer #(
   parameter int BITS   = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2*BITS-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*BITS-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              full
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int W     = 2 * BITS;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      FILL,
      DRAIN
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [W-1:0]      mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_addr;
   logic              wr_en;
   logic              rd_en;

`ifdef FFT_SAMPLE_BUFFER_BITREV_EN
   for (genvar g = 0; g < ADDR_W; g++) begin : g_rev
      assign rd_addr[g] = rd_ptr[ADDR_W-1-g];
   end
`else
   assign rd_addr = rd_ptr;
`endif

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      full      = 1'b0;
      unique case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && wr_ptr == LAST)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            full      = 1'b1;
            if (out_ready && rd_ptr == LAST)
               state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
      // flush overrides any handshake in the same cycle
      if (flush)
         state_nxt = FILL;
   end

   assign wr_en     = in_valid & in_ready & ~flush;
   assign rd_en     = out_valid & out_ready & ~flush;
   assign out_index = rd_ptr;
   assign out_last  = full & (rd_ptr == LAST);
   assign out_data  = full ? mem[rd_addr] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= FILL;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) begin
               mem[wr_ptr] <= in_data;
               wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Randomised bench for fft_sample_buffer against a frame-level model.
// Honours FFT_SAMPLE_BUFFER_BITREV_EN for the expected drain order.
module tb_fft_sample_buffer;

   localparam int BITS   = 16;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int W      = 2 * BITS;

   logic              clk;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [W-1:0]      in_data;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_last;
   logic              full;

   fft_sample_buffer #(.BITS(BITS), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_index(out_index),
      .out_last (out_last),
      .full     (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // model: captured frame, fill count, drain position
   logic [W-1:0] frame [DEPTH];
   int           wcnt;
   int           ridx;
   bit           mfull;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic int src_of(input int seq);
      int r;
`ifdef FFT_SAMPLE_BUFFER_BITREV_EN
      r = 0;
      for (int b = 0; b < ADDR_W; b++)
         if (seq & (1 << b))
            r = r | (1 << (ADDR_W - 1 - b));
`else
      r = seq;
`endif
      return r;
   endfunction

   task automatic model_reset(input bit clear);
      wcnt  = 0;
      ridx  = 0;
      mfull = 0;
      if (clear)
         for (int i = 0; i < DEPTH; i++)
            frame[i] = '0;
   endtask

   task automatic check_outs();
      logic [W-1:0] ed;
      ed = mfull ? frame[src_of(ridx)] : '0;
      chk("in_ready", 64'(in_ready), 64'(!mfull));
      chk("out_valid", 64'(out_valid), 64'(mfull));
      chk("full", 64'(full), 64'(mfull));
      chk("out_index", 64'(out_index), 64'(mfull ? ridx : 0));
      chk("out_last", 64'(out_last), 64'(mfull && ridx == DEPTH - 1));
      chk("out_data", 64'(out_data), 64'(ed));
   endtask

   task automatic cyc(input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      check_outs();
      if (fl) begin
         model_reset(0);
      end else if (!mfull) begin
         if (iv) begin
            frame[wcnt] = d;
            wcnt++;
            if (wcnt == DEPTH) begin
               mfull = 1;
               ridx  = 0;
            end
         end
      end else if (ordy) begin
         ridx++;
         if (ridx == DEPTH) begin
            mfull = 0;
            ridx  = 0;
            wcnt  = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] ramp(input int k);
      logic [BITS-1:0] kk;
      kk = BITS'(k);
      return {kk, -kk};
   endfunction

   task automatic drain_all(input logic iv, input logic [W-1:0] d);
      for (int c = 0; c < 4 * DEPTH && mfull; c++)
         cyc(iv, d, 1'b1, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset(1);
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_index", 64'(out_index), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      #5;
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // natural ramp frame, back-to-back
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b1, ramp(k), 1'b1, 1'b0);
      drain_all(1'b0, '0);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // sparse writes, stalled read at index 5
      begin
         int k;
         int hold;
         k = 0;
         hold = 0;
         for (int c = 0; c < 4 * DEPTH && !mfull; c++) begin
            if (c % 2 == 0) begin
               cyc(1'b1, ramp(k), 1'b0, 1'b0);
               k++;
            end else begin
               cyc(1'b0, 32'h5555_5555, 1'b1, 1'b0);
            end
         end
         for (int c = 0; c < 4 * DEPTH && mfull; c++) begin
            if (ridx == 5 && hold < 3) begin
               hold++;
               cyc(1'b0, '0, 1'b0, 1'b0);
            end else begin
               cyc(1'b0, '0, 1'b1, 1'b0);
            end
         end
      end

      // partial frame, flush, fresh frame
      for (int k = 0; k < 10; k++)
         cyc(1'b1, 32'hAAAA_0000 + W'(k), 1'b1, 1'b0);
      cyc(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1);
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b1, 32'h0000_1000 + W'(k), 1'b1, 1'b0);
      drain_all(1'b0, '0);

      // async reset mid-drain at index 12
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b1, ramp(k + 7), 1'b0, 1'b0);
      for (int c = 0; c < DEPTH && ridx < 12; c++)
         cyc(1'b0, '0, 1'b1, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_full", 64'(full), 64'd0);
      reset = 1'b0;
      #1;
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      model_reset(1);
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b1, 32'h0000_2000 + W'(k), 1'b1, 1'b0);
      drain_all(1'b0, '0);

      // writes attempted throughout a drain
      for (int k = 0; k < DEPTH; k++)
         cyc(1'b1, W'($urandom), 1'b0, 1'b0);
      drain_all(1'b1, 32'hDEAD_BEEF);

      // random traffic with occasional flush
      for (int c = 0; c < 3000; c++)
         cyc(1'($urandom_range(0, 1)), W'($urandom),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 99) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
Parametrised complex-sample frame buffer for the FFT datapath.
- Accepts one frame of 2^ADDR_W complex samples in arrival order over a valid/ready input.
- Once the frame is complete, streams it out over a valid/ready output, in natural order or, with the optional feature, in bit-reversed order.
- Sits between the input sample source and the first butterfly stage.
- Supersedes fixed 4-entry one-hot-enable register banks.

Parameters:
- BITS, 16: width of each real and imaginary part. A sample is 2*BITS wide: {re, im}.
- ADDR_W, 5: log2 of the frame depth. DEPTH = 2^ADDR_W, so the default is 32 points.

Ports:
- clk, input, 1: clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous abort. Returns the block to FILL with pointers at 0.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: the block can accept a sample.
- in_data, input, 2*BITS: complex input sample.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: the consumer accepts out_data.
- out_data, output, 2*BITS: complex output sample.
- out_index, output, ADDR_W: output sequence number, 0..DEPTH-1.
- out_last, output, 1: high on the final sample of a frame.
- full, output, 1: a complete frame is held (state is DRAIN).

Behaviour:
- Storage: DEPTH x 2*BITS register array. Two pointers, wr_ptr and rd_ptr, each ADDR_W bits.
- FSM has 2 states: FILL and DRAIN.
- Reset (asynchronous, active-high, on clock clk):
  - state = FILL; wr_ptr = rd_ptr = 0.
  - All array entries = 0.
  - in_ready = 1 once reset is released; out_valid = 0, out_last = 0, full = 0, out_index = 0, out_data = 0.
- FILL state:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: mem[wr_ptr] <= in_data, wr_ptr <= wr_ptr + 1.
  - A write at wr_ptr = DEPTH-1 wraps wr_ptr to 0 and moves the FSM to DRAIN on the same edge.
  - No write occurs when in_valid = 0. The pointer holds.
- DRAIN state:
  - in_ready = 0. in_valid is ignored and nothing is written.
  - out_valid = 1, full = 1, out_index = rd_ptr, out_last = (rd_ptr == DEPTH-1).
  - out_data = mem[rd_addr], combinational from the array with no read latency. rd_addr = rd_ptr in natural mode.
  - On out_valid & out_ready: rd_ptr <= rd_ptr + 1.
  - A transfer with out_last = 1 wraps rd_ptr to 0 and returns the FSM to FILL.
  - With out_ready = 0, out_data, out_index and out_last hold stable.
- Latency:
  - The last input write is at edge N. out_valid rises after edge N, so the first output is available in cycle N+1.
  - The last output transfer is at edge M. in_ready = 1 in cycle M+1.
- Throughput: one sample per clock in each direction. No overlap between fill and drain; it is a single buffer.
- flush:
  - Synchronous. Takes priority over all handshakes in that cycle.
  - Sets state = FILL and both pointers = 0. Array contents are not cleared.
  - A write or read coinciding with flush is discarded.
- reset mid-frame: the partial frame is lost. The block restarts at FILL with index 0.
- out_ready during FILL and in_valid during DRAIN have no effect.

Optional Feature:
- Macro: FFT_SAMPLE_BUFFER_BITREV_EN
- Defined: rd_addr = bit-reverse of rd_ptr over ADDR_W bits. Samples leave in bit-reversed order for the DIT FFT. out_index still reports rd_ptr, the sequence number.
- Undefined: rd_addr = rd_ptr. Natural order. No reversal logic is synthesised.

Test Plan:
1. Reset, then 32 consecutive writes of sample k = {re = k, im = -k} with out_ready = 1 -> in_ready falls after write 31. out_valid is high for 32 cycles with out_data = sample 0..31 in order. out_last is high only at index 31. in_ready = 1 on the next cycle.
2. Same frame with FFT_SAMPLE_BUFFER_BITREV_EN defined -> outputs at out_index 0,1,2,3 carry samples 0,16,8,24. Index 31 carries sample 31.
3. Write with in_valid toggling every other cycle, then drain with out_ready low for 3 cycles at index 5 -> no samples are lost or duplicated. out_data = sample 5 is held for all 4 cycles until accepted.
4. Write 10 samples, assert flush for 1 cycle, then write a new 32-sample frame of value 0x1000+k -> output is the new frame only, starting at index 0.
5. Assert reset asynchronously, between clock edges, in the middle of DRAIN at index 12 -> out_valid = 0 and in_ready = 1 with no clock edge needed. The next frame is written from index 0, and its drain returns the new data.
6. In DRAIN, hold in_valid = 1 with data 0xDEAD_BEEF for the whole drain -> the stored frame is unchanged and in_ready stays 0.
